fifo_mport: RTL



---
 rtl/fifo_mport_pkg.sv | 40 ++++
 rtl/fifo_lane_compactor.sv | 26 ++
 rtl/fifo_mport.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fifo_mport_pkg.sv
// Shared types and helpers for the multi-port FIFO: lane popcount, the
// leading-ones run used to size a dequeue, and pointer/count width helpers.
package fifo_mport_pkg;

    localparam int unsigned MaxLanes = 32;

    typedef logic [MaxLanes-1:0]            lane_vec_t;
    typedef logic [$clog2(MaxLanes+1)-1:0]  lane_cnt_t;

    function automatic lane_cnt_t popcount(input lane_vec_t v);
        lane_cnt_t n;
        n = '0;
        for (int i = 0; i < MaxLanes; i++) begin
            n = n + lane_cnt_t'(v[i]);
        end
        return n;
    endfunction

    // Length of the unbroken run of ones starting at bit 0.
    function automatic lane_cnt_t ones_run(input lane_vec_t v);
        lane_cnt_t n;
        logic      run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < MaxLanes; i++) begin
            run = run & v[i];
            n   = n + lane_cnt_t'(run);
        end
        return n;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_lane_compactor.sv
// Combinational lane compactor: gives each enabled enqueue lane its slot
// offset from tail (ascending lane order) and the total number enabled.
module fifo_lane_compactor
    import fifo_mport_pkg::*;
#(
    parameter int unsigned N_IN = 2
) (
    input  logic      [N_IN-1:0] i_en,
    output lane_cnt_t [N_IN-1:0] o_offset,
    output logic      [N_IN-1:0] o_valid,
    output lane_cnt_t            o_n_enq
);

    always_comb begin
        lane_cnt_t w_run;
        w_run = '0;
        for (int i = 0; i < N_IN; i++) begin
            o_offset[i] = w_run;
            w_run       = w_run + lane_cnt_t'(i_en[i]);
        end
    end

    assign o_valid = i_en;
    assign o_n_enq = popcount(lane_vec_t'(i_en));

endmodule

// File: rtl/fifo_mport.sv
// Multi-port FIFO with N_IN enqueue and N_OUT dequeue lanes, count-based full/empty.
// Optional statistics ports (drop_cnt, hwm) are built when FIFO_MPORT_STATS_EN is defined.
module fifo_mport
    import fifo_mport_pkg::*;
#(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned N_IN   = 2,
    parameter int unsigned N_OUT  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_IN-1:0]            in_en,
    input  logic [N_IN*DWIDTH-1:0]     in_data,
    output logic                       in_ready,
    input  logic [N_OUT-1:0]           out_deq_en,
    output logic [N_OUT-1:0]           out_valid,
    output logic [N_OUT*DWIDTH-1:0]    out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
`ifdef FIFO_MPORT_STATS_EN
    ,
    output logic [15:0]                drop_cnt,
    output logic [$clog2(DEPTH+1)-1:0] hwm
`endif
);

    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned CW = cnt_width(DEPTH);

    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < N_IN) || (DEPTH < N_OUT) ||
        (N_IN < 1) || (N_OUT < 1) || (N_IN > MaxLanes) || (N_OUT > MaxLanes)) begin : g_bad_cfg
        $fatal(1, "fifo_mport: DEPTH must be a power of two >= N_IN and N_OUT");
    end

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;

    lane_cnt_t [N_IN-1:0] w_offset;
    logic      [N_IN-1:0] w_lane_valid;
    lane_cnt_t            w_n_enq;
    lane_cnt_t            w_n_enq_fired;
    lane_cnt_t            w_n_deq;
    logic      [N_OUT-1:0] w_deq_mask;
    logic      [CW-1:0]   w_count_d;
    logic      [PW-1:0]   w_waddr [N_IN];
    logic      [DEPTH-1:0] w_we;
    logic      [DWIDTH-1:0] w_wd [DEPTH];

    fifo_lane_compactor #(
        .N_IN (N_IN)
    ) u_compactor (
        .i_en     (in_en),
        .o_offset (w_offset),
        .o_valid  (w_lane_valid),
        .o_n_enq  (w_n_enq)
    );

    // Status depends only on registered state, never on same-cycle requests.
    assign in_ready = (r_count <= CW'(DEPTH - N_IN));
    assign empty    = (r_count == '0);
    assign full     = (r_count == CW'(DEPTH));
    assign count    = r_count;

    always_comb begin
        for (int k = 0; k < N_OUT; k++) begin
            out_valid[k]                   = (r_count > CW'(k));
            out_data[k*DWIDTH +: DWIDTH]   = r_mem[r_head + PW'(k)];
        end
    end

    assign w_deq_mask    = out_deq_en & out_valid;
    assign w_n_deq       = ones_run(lane_vec_t'(w_deq_mask));
    assign w_n_enq_fired = in_ready ? w_n_enq : '0;
    assign w_count_d     = r_count + CW'(w_n_enq_fired) - CW'(w_n_deq);

    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            w_waddr[i] = r_tail + PW'(w_offset[i]);
        end
        for (int e = 0; e < DEPTH; e++) begin
            w_we[e] = 1'b0;
            w_wd[e] = '0;
        end
        for (int i = 0; i < N_IN; i++) begin
            if (in_ready && w_lane_valid[i]) begin
                w_we[w_waddr[i]] = 1'b1;
                w_wd[w_waddr[i]] = in_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_we[e]) begin
                    r_mem[e] <= w_wd[e];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_n_deq);
            r_tail  <= r_tail + PW'(w_n_enq_fired);
            r_count <= w_count_d;
        end
    end

`ifdef FIFO_MPORT_STATS_EN
    logic [15:0]   r_drop_cnt;
    logic [CW-1:0] r_hwm;
    logic [16:0]   w_drop_sum;

    assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(popcount(lane_vec_t'(in_en)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
            r_hwm      <= '0;
        end else begin
            if (!in_ready) begin
                r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            end
            if (w_count_d > r_hwm) begin
                r_hwm <= w_count_d;
            end
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign hwm      = r_hwm;
`endif

endmodule
